peak_finder: RTL and testbench
==============================

# peak_finder

Downstream stage for any vN_filter output in the filter top level. Scans the filtered ADC stream for pulses crossing a programmable threshold and extracts per-pulse data: peak amplitude, peak timestamp, time-over-threshold width and a pile-up flag. Each pulse yields one event record, delivered over a valid/ready handshake with a one-deep output register, so a slow consumer (histogrammer, readout FIFO) can be attached.

## Interface
Parameters:
- DATA_WIDTH, 16 (equals SIZE_FILTER_DATA): width of input_data, threshold and out_amplitude; all signed two's complement.
- TIME_WIDTH, 32: timestamp counter width.
- WIDTH_BITS, 8: width of out_width; saturating.
- HOLDOFF, 8: dead-time cycles after each event; range 0..255.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- input_data  in  DATA_WIDTH  filter output sample, one per cycle, signed.
- threshold  in  DATA_WIDTH  trigger level, signed; sampled every cycle.
- enable  in  1  allows arming from IDLE.
- out_ready  in  1  consumer accepts the record.
- out_valid  out  1  record held in the output register.
- out_amplitude  out  DATA_WIDTH  maximum sample of the pulse.
- out_time  out  TIME_WIDTH  timestamp of the first sample equal to the maximum.
- out_width  out  WIDTH_BITS  number of samples > threshold, saturating at 2^WIDTH_BITS-1.
- out_pileup  out  1  second rise detected inside the pulse.
- lost_count  out  16  records dropped because the output register was full; saturates at 65535.

## Operation
- Timestamp: free-running counter, 0 during reset, wraps modulo 2^TIME_WIDTH. A sample presented in cycle c (c=0 = first cycle with reset low) carries timestamp c.
- Input is registered once as sample x; prev holds the preceding x. All comparisons are signed.
- States: IDLE, ABOVE, HOLD.
- IDLE: if enable and x > threshold, go to ABOVE with amp=x, time=ts(x), width=1, falling=0, pileup=0.
- ABOVE, x > threshold: width += 1 (saturating). If x > amp, set amp=x and time=ts(x); ties keep the earlier time. If x < prev, set falling=1. If falling and x > prev, set pileup=1. enable is ignored in this state.
- ABOVE, x <= threshold: emit the record. Go to HOLD with counter=HOLDOFF; if HOLDOFF=0, go directly to IDLE.
- HOLD: input is ignored. Counter decrements; go to IDLE when the counter reaches 0. Exactly HOLDOFF cycles are spent in HOLD.
- Emit with out_valid=0, or with out_valid=1 and out_ready=1: load the record and set out_valid=1.
- Emit with out_valid=1 and out_ready=0: drop the new record, keep the held one, increment lost_count.
- No emit, and out_valid and out_ready both high: clear out_valid.
- Output fields are stable while out_valid=1 and out_ready=0.
- Threshold changes take effect on the next compare. No retrigger or abort mid-pulse.

## Timing
- Reset values: state=IDLE, timestamp=0, out_valid=0, out_amplitude=0, out_time=0, out_width=0, out_pileup=0, lost_count=0. All internal registers, including prev, are cleared.
- Reset asserted mid-pulse or while out_valid=1: the pending record is discarded and no partial event is emitted.
- Latency: first sample <= threshold presented in cycle c gives out_valid=1 in cycle c+2.
- Throughput: one sample per cycle, no stalls. Minimum event spacing is width+HOLDOFF+1 samples.
- Pulse starting in the first cycle after IDLE is re-entered: accepted.
- Timestamp wrap inside a pulse: out_time is the raw wrapped value; no correction.

## Test plan
- Single pulse: threshold=100, HOLDOFF=4, samples 0,0,50,150,300,420,420,380,200,90,0 starting at cycle 10 → one record: amplitude 420, time 15, width 6, pileup 0, out_valid at cycle 21.
- Pile-up and holdoff: 150,300,250,350,200,50 with threshold 100 → amplitude 350, pileup 1, width 5. A pulse arriving inside the 4 HOLD cycles produces no record. The same pulse arriving on the first cycle after HOLD produces a record.
- Backpressure: out_ready=0 while two pulses complete → first record held unchanged, lost_count=1. out_ready=1 in the same cycle as a third emit → third record loaded, out_valid stays 1.
- Width saturation and negative data: WIDTH_BITS=4, 20 samples above threshold=-500 → out_width 15. A pulse peaking at -10 reports amplitude -10.
- Reset mid-pulse: assert reset during ABOVE and while out_valid=1 → all outputs at reset values next cycle, no record emitted. A following pulse is timestamped from 0.
- enable=0 with pulses present → no records, lost_count unchanged. enable dropped mid-pulse → that pulse still completes.

Source files
------------

// File: rtl/peak_finder.sv
// Pulse extractor for a filtered ADC stream: tracks peak amplitude, peak time, time-over-threshold
// and pile-up per pulse, and hands out one record per pulse through a one-deep valid/ready register.
module peak_finder #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned TIME_WIDTH = 32,
   parameter int unsigned WIDTH_BITS = 8,
   parameter int unsigned HOLDOFF    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] input_data,
   input  logic [DATA_WIDTH-1:0] threshold,
   input  logic                  enable,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_amplitude,
   output logic [TIME_WIDTH-1:0] out_time,
   output logic [WIDTH_BITS-1:0] out_width,
   output logic                  out_pileup,
   output logic [15:0]           lost_count
);

   typedef enum logic [1:0] {StIdle, StAbove, StHold} state_e;

   localparam logic [7:0]            HoldInit = 8'(HOLDOFF);
   localparam logic [WIDTH_BITS-1:0] WidthMax = {WIDTH_BITS{1'b1}};

   state_e                  state_q, state_d;
   logic [TIME_WIDTH-1:0]   ts_q, ts_x_q;
   logic [DATA_WIDTH-1:0]   x_q, prev_q;
   logic [DATA_WIDTH-1:0]   amp_q, amp_d;
   logic [TIME_WIDTH-1:0]   time_q, time_d;
   logic [WIDTH_BITS-1:0]   width_q, width_d;
   logic                    falling_q, falling_d;
   logic                    pileup_q, pileup_d;
   logic [7:0]              hold_q, hold_d;
   logic                    valid_q, valid_d;
   logic [DATA_WIDTH-1:0]   o_amp_q, o_amp_d;
   logic [TIME_WIDTH-1:0]   o_time_q, o_time_d;
   logic [WIDTH_BITS-1:0]   o_width_q, o_width_d;
   logic                    o_pileup_q, o_pileup_d;
   logic [15:0]             lost_q, lost_d;
   logic                    above, emit;

   assign above = $signed(x_q) > $signed(threshold);
   assign emit  = (state_q == StAbove) && !above;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         ts_q       <= '0;
         ts_x_q     <= '0;
         x_q        <= '0;
         prev_q     <= '0;
         amp_q      <= '0;
         time_q     <= '0;
         width_q    <= '0;
         falling_q  <= 1'b0;
         pileup_q   <= 1'b0;
         hold_q     <= '0;
         valid_q    <= 1'b0;
         o_amp_q    <= '0;
         o_time_q   <= '0;
         o_width_q  <= '0;
         o_pileup_q <= 1'b0;
         lost_q     <= '0;
      end else begin
         state_q    <= state_d;
         ts_q       <= ts_q + TIME_WIDTH'(1);
         // The sample carries the timestamp of the cycle it was presented in.
         ts_x_q     <= ts_q;
         x_q        <= input_data;
         prev_q     <= x_q;
         amp_q      <= amp_d;
         time_q     <= time_d;
         width_q    <= width_d;
         falling_q  <= falling_d;
         pileup_q   <= pileup_d;
         hold_q     <= hold_d;
         valid_q    <= valid_d;
         o_amp_q    <= o_amp_d;
         o_time_q   <= o_time_d;
         o_width_q  <= o_width_d;
         o_pileup_q <= o_pileup_d;
         lost_q     <= lost_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      amp_d     = amp_q;
      time_d    = time_q;
      width_d   = width_q;
      falling_d = falling_q;
      pileup_d  = pileup_q;
      hold_d    = hold_q;
      unique case (state_q)
         StIdle: begin
            if (enable && above) begin
               state_d   = StAbove;
               amp_d     = x_q;
               time_d    = ts_x_q;
               width_d   = WIDTH_BITS'(1);
               falling_d = 1'b0;
               pileup_d  = 1'b0;
            end
         end
         StAbove: begin
            if (above) begin
               if (width_q != WidthMax) width_d = width_q + WIDTH_BITS'(1);
               // Strict compare keeps the earliest sample of a flat-topped peak.
               if ($signed(x_q) > $signed(amp_q)) begin
                  amp_d  = x_q;
                  time_d = ts_x_q;
               end
               if ($signed(x_q) < $signed(prev_q)) falling_d = 1'b1;
               if (falling_q && ($signed(x_q) > $signed(prev_q))) pileup_d = 1'b1;
            end else begin
               hold_d  = HoldInit;
               state_d = (HOLDOFF == 0) ? StIdle : StHold;
            end
         end
         StHold: begin
            hold_d = hold_q - 8'd1;
            if (hold_q <= 8'd1) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      valid_d    = valid_q;
      o_amp_d    = o_amp_q;
      o_time_d   = o_time_q;
      o_width_d  = o_width_q;
      o_pileup_d = o_pileup_q;
      lost_d     = lost_q;
      if (emit) begin
         if (!valid_q || out_ready) begin
            valid_d    = 1'b1;
            o_amp_d    = amp_q;
            o_time_d   = time_q;
            o_width_d  = width_q;
            o_pileup_d = pileup_q;
         end else if (lost_q != 16'hFFFF) begin
            lost_d = lost_q + 16'd1;
         end
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   assign out_valid     = valid_q;
   assign out_amplitude = o_amp_q;
   assign out_time      = o_time_q;
   assign out_width     = o_width_q;
   assign out_pileup    = o_pileup_q;
   assign lost_count    = lost_q;

endmodule

// File: tb/tb_peak_finder.sv
// Directed bench for peak_finder: linear stimulus with hand-computed records, HOLDOFF=4 and a
// 4-bit width field so saturation is reachable.
module tb_peak_finder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] input_data;
   logic [15:0] threshold;
   logic        enable;
   logic        out_ready;
   logic        out_valid;
   logic [15:0] out_amplitude;
   logic [31:0] out_time;
   logic [3:0]  out_width;
   logic        out_pileup;
   logic [15:0] lost_count;

   int cyc    = 0;
   int nassert = 0;
   int nfail  = 0;

   peak_finder #(
      .DATA_WIDTH(16),
      .TIME_WIDTH(32),
      .WIDTH_BITS(4),
      .HOLDOFF   (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .input_data   (input_data),
      .threshold    (threshold),
      .enable       (enable),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_amplitude(out_amplitude),
      .out_time     (out_time),
      .out_width    (out_width),
      .out_pileup   (out_pileup),
      .lost_count   (lost_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nassert++;
      assert (obs === expv)
      else begin
         nfail++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
      end
   endtask

   // Present d for the current cycle, then move to the next cycle (#1 after the edge).
   task automatic step(input logic [15:0] d);
      input_data = d;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int c, input logic [15:0] d);
      while (cyc < c) step(d);
   endtask

   task automatic chk_rec(input string tag, input logic [15:0] amp, input logic [31:0] t,
                          input logic [3:0] w, input logic p);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_amp"}, 32'(out_amplitude), 32'(amp));
      chk({tag, "_time"}, out_time, t);
      chk({tag, "_width"}, 32'(out_width), 32'(w));
      chk({tag, "_pileup"}, 32'(out_pileup), 32'(p));
   endtask

   initial begin
      reset      = 1'b1;
      input_data = '0;
      threshold  = 16'd100;
      enable     = 1'b1;
      out_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;

      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_amp", 32'(out_amplitude), 32'd0);
      chk("rst_time", out_time, 32'd0);
      chk("rst_width", 32'(out_width), 32'd0);
      chk("rst_pileup", 32'(out_pileup), 32'd0);
      chk("rst_lost", 32'(lost_count), 32'd0);

      // Single pulse, samples from cycle 10
      run_to(10, 16'd0);
      step(16'd0); step(16'd0); step(16'd50); step(16'd150); step(16'd300);
      step(16'd420); step(16'd420); step(16'd380); step(16'd200); step(16'd90);
      chk("single_latency", 32'(out_valid), 32'd0);
      step(16'd0);
      chk_rec("single", 16'd420, 32'd15, 4'd6, 1'b0);
      step(16'd0);
      chk("single_consumed", 32'(out_valid), 32'd0);

      // Pulse inside HOLD (cycles 21..24) is ignored
      step(16'd200); step(16'd200);
      run_to(26, 16'd0);
      chk("hold_c26", 32'(out_valid), 32'd0);
      step(16'd0);
      chk("hold_c27", 32'(out_valid), 32'd0);

      // Pile-up pulse
      run_to(30, 16'd0);
      step(16'd150); step(16'd300); step(16'd250); step(16'd350); step(16'd200); step(16'd50);
      step(16'd0);
      chk_rec("pileup", 16'd350, 32'd33, 4'd5, 1'b1);

      // Same pulse on the first cycle after HOLD (HOLD = cycles 37..40)
      run_to(40, 16'd0);
      step(16'd150); step(16'd300); step(16'd250); step(16'd350); step(16'd200); step(16'd50);
      chk("rearm_latency", 32'(out_valid), 32'd0);
      step(16'd0);
      chk_rec("rearm", 16'd350, 32'd43, 4'd5, 1'b1);

      // Backpressure
      run_to(50, 16'd0);
      out_ready = 1'b0;
      step(16'd200); step(16'd500); step(16'd200); step(16'd0);
      run_to(55, 16'd0);
      chk_rec("bp_first", 16'd500, 32'd51, 4'd3, 1'b0);
      run_to(58, 16'd0);
      step(16'd300); step(16'd300); step(16'd0); step(16'd0);
      chk_rec("bp_held", 16'd500, 32'd51, 4'd3, 1'b0);
      chk("bp_lost", 32'(lost_count), 32'd1);
      run_to(65, 16'd0);
      step(16'd700); step(16'd0);
      out_ready = 1'b1;
      step(16'd0);
      chk_rec("bp_third", 16'd700, 32'd65, 4'd1, 1'b0);
      chk("bp_lost_keep", 32'(lost_count), 32'd1);
      step(16'd0);
      chk("bp_drain", 32'(out_valid), 32'd0);

      // Negative data, threshold -500, 20 samples above -> width saturates at 15
      run_to(70, 16'd0);
      run_to(75, 16'hFC18);
      threshold = 16'hFE0C;
      run_to(80, 16'hFC18);
      for (int i = 0; i < 20; i++) step((i == 5) ? 16'hFFF6 : 16'hFF9C);
      step(16'hFC18);
      chk("neg_latency", 32'(out_valid), 32'd0);
      step(16'hFC18);
      chk_rec("neg", 16'hFFF6, 32'd85, 4'd15, 1'b0);
      run_to(104, 16'hFC18);
      threshold = 16'd100;

      // Reset while in ABOVE with a record held
      run_to(110, 16'd0);
      out_ready = 1'b0;
      step(16'd200); step(16'd0);
      run_to(116, 16'd0);
      step(16'd400); step(16'd400); step(16'd400);
      chk("pre_reset_valid", 32'(out_valid), 32'd1);
      reset = 1'b1;
      step(16'd400);
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_amp", 32'(out_amplitude), 32'd0);
      chk("mrst_time", out_time, 32'd0);
      chk("mrst_width", 32'(out_width), 32'd0);
      chk("mrst_lost", 32'(lost_count), 32'd0);
      reset     = 1'b0;
      out_ready = 1'b1;
      cyc       = 0;
      step(16'd500); step(16'd400); step(16'd0);
      chk("post_rst_no_partial", 32'(out_valid), 32'd0);
      step(16'd0);
      chk_rec("post_rst", 16'd500, 32'd0, 4'd2, 1'b0);

      // enable=0 blocks arming
      run_to(10, 16'd0);
      enable = 1'b0;
      run_to(12, 16'd0);
      step(16'd300); step(16'd300); step(16'd0);
      run_to(16, 16'd0);
      chk("dis_c16", 32'(out_valid), 32'd0);
      step(16'd0);
      chk("dis_c17", 32'(out_valid), 32'd0);
      chk("dis_lost", 32'(lost_count), 32'd0);

      // enable dropped mid-pulse: pulse still completes
      run_to(19, 16'd0);
      enable = 1'b1;
      step(16'd0); step(16'd300); step(16'd600);
      enable = 1'b0;
      step(16'd300); step(16'd0); step(16'd0);
      chk_rec("en_drop", 16'd600, 32'd21, 4'd3, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end

endmodule
